// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port, multi-cycle unified memory between the
// instruction-fetch port (read only) and the MEM-stage data port (read/write).
// Accesses are serialized through IDLE -> ACCESS -> RESP; each completed
// access produces a one-cycle ready pulse for the granted requester, and
// stall_if / stall_dm let the hazard logic freeze the IF and MEM stages.
//
// Optional feature: define DM_ARB_ROUND_ROBIN_EN to replace the fixed
// DM-over-IF priority with round-robin arbitration through a last_grant
// register (reset to IF). The default build uses fixed priority.
module dm_arbiter #(
  parameter int LATENCY = 4,  // memory access cycles, legal range 1..7
  parameter int CNT_W   = 3   // latency down-counter width, holds LATENCY-1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch port
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  // MEM-stage data port
  input  logic        dm_re,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_ready,
  // hazard-unit stalls
  output logic        stall_if,
  output logic        stall_dm,
  // memory side
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IF   = 2'd1,
    G_DM   = 2'd2
  } grant_t;

  state_t             state_r;
  state_t             state_nxt_s;
  grant_t             grant_r;
  grant_t             grant_sel_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [15:0]        addr_r;
  logic [15:0]        wdata_r;
  logic               we_r;
  logic [15:0]        if_rdata_r;
  logic [15:0]        dm_rdata_r;
  logic               dm_pend_s;
  logic               accept_s;
  logic               last_cycle_s;

`ifdef DM_ARB_ROUND_ROBIN_EN
  // 1'b0: IF was granted last, 1'b1: DM was granted last
  logic               last_grant_r;
`endif

  // Pick the requester to grant when the arbiter is idle.
  always_comb begin
    dm_pend_s   = dm_re | dm_we;
    grant_sel_s = G_NONE;
    if (dm_pend_s && if_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
      if (last_grant_r) begin
        grant_sel_s = G_IF;
      end else begin
        grant_sel_s = G_DM;
      end
`else
      grant_sel_s = G_DM;
`endif
    end else if (dm_pend_s) begin
      grant_sel_s = G_DM;
    end else if (if_req) begin
      grant_sel_s = G_IF;
    end else begin
      grant_sel_s = G_NONE;
    end
  end

  // Qualifiers shared by the state machine and the datapath.
  always_comb begin
    accept_s     = (state_r == S_IDLE) && (grant_sel_s != G_NONE);
    last_cycle_s = (state_r == S_ACCESS) && (cnt_r == {CNT_W{1'b0}});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_sel_s != G_NONE) begin
          state_nxt_s = S_ACCESS;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_ACCESS;
        end
      end
      S_RESP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Capture the accepted request and run the latency down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r <= G_NONE;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      we_r    <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      grant_r <= grant_sel_s;
      cnt_r   <= CNT_W'(LATENCY - 1);
      if (grant_sel_s == G_DM) begin
        addr_r  <= dm_addr;
        wdata_r <= dm_wdata;
        // a simultaneous read+write request is served as a write
        we_r    <= dm_we;
      end else begin
        addr_r  <= if_addr;
        wdata_r <= 16'h0000;
        we_r    <= 1'b0;
      end
    end else if ((state_r == S_ACCESS) && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else if (state_r == S_RESP) begin
      grant_r <= G_NONE;
    end
  end

`ifdef DM_ARB_ROUND_ROBIN_EN
  // Remember which requester won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b0;
    end else if (accept_s) begin
      last_grant_r <= (grant_sel_s == G_DM);
    end
  end
`endif

  // Register read data into the granted requester's holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_r <= 16'h0000;
      dm_rdata_r <= 16'h0000;
    end else if (last_cycle_s && !we_r) begin
      if (grant_r == G_IF) begin
        if_rdata_r <= mem_rdata;
      end else if (grant_r == G_DM) begin
        dm_rdata_r <= mem_rdata;
      end
    end
  end

  // Output decode from registered state and capture registers.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    case (state_r)
      S_ACCESS: begin
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        if (grant_r != G_NONE) begin
          mem_re = ~we_r;
          mem_we = we_r;
        end else begin
          mem_re = 1'b0;
          mem_we = 1'b0;
        end
      end
      S_RESP: begin
        if_ready = (grant_r == G_IF);
        dm_ready = (grant_r == G_DM);
      end
      default: begin
        mem_addr = 16'h0000;
      end
    endcase
  end

  // Stalls hold the requesting stage until its ready pulse arrives.
  always_comb begin
    stall_if = if_req & ~if_ready;
    stall_dm = (dm_re | dm_we) & ~dm_ready;
  end

  assign if_rdata = if_rdata_r;
  assign dm_rdata = dm_rdata_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter (LATENCY = 4) with a small behavioural
// memory that returns data combinationally and commits writes on the strobe.
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic        dm_re;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_ready;
  logic        stall_if;
  logic        stall_dm;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  int n_vec;
  int n_bad;

  dm_arbiter #(.LATENCY(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_re     (dm_re),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .stall_if  (stall_if),
    .stall_dm  (stall_dm),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: preload port for the bench, write port for the DUT
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_addr[15:8] == 8'h00) ? mem[mem_addr[7:0]] : 16'hDEAD;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one cycle, leaving the bench at the next falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 16'h0000;
    dm_re = 1'b0; dm_we = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 16'h0000;

    @(negedge clk);
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 16'hBEEF;
    @(negedge clk);
    pre_addr = 8'h40; pre_data = 16'h0F0F;
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    // reset state
    check_val("rst_if_rdata", if_rdata, 16'h0000);
    check_val("rst_dm_rdata", dm_rdata, 16'h0000);
    check_val("rst_mem_re", {15'd0, mem_re}, 16'd0);
    check_val("rst_mem_we", {15'd0, mem_we}, 16'd0);
    check_val("rst_mem_addr", mem_addr, 16'h0000);
    check_val("rst_mem_wdata", mem_wdata, 16'h0000);
    check_val("rst_ready", {14'd0, if_ready, dm_ready}, 16'd0);
    rst = 1'b0;
    step();

    // IF read of 0x0010 -> 0xBEEF
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    check_val("if0_stall", {15'd0, stall_if}, 16'd1);
    check_val("if0_mem_re", {15'd0, mem_re}, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val("if_acc_re", {15'd0, mem_re}, 16'd1);
      check_val("if_acc_we", {15'd0, mem_we}, 16'd0);
      check_val("if_acc_addr", mem_addr, 16'h0010);
      check_val("if_acc_stall", {15'd0, stall_if}, 16'd1);
      check_val("if_acc_ready", {15'd0, if_ready}, 16'd0);
    end
    step();
    check_val("if5_ready", {15'd0, if_ready}, 16'd1);
    check_val("if5_rdata", if_rdata, 16'hBEEF);
    check_val("if5_stall", {15'd0, stall_if}, 16'd0);
    check_val("if5_dm_ready", {15'd0, dm_ready}, 16'd0);
    check_val("if5_mem_re", {15'd0, mem_re}, 16'd0);
    if_req = 1'b0;
    step();
    check_val("if6_ready", {15'd0, if_ready}, 16'd0);
    check_val("if6_rdata_hold", if_rdata, 16'hBEEF);

    // DM write 0x1234 to 0x0020
    dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    #1;
    check_val("wr0_stall", {15'd0, stall_dm}, 16'd1);
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val("wr_acc_we", {15'd0, mem_we}, 16'd1);
      check_val("wr_acc_re", {15'd0, mem_re}, 16'd0);
      check_val("wr_acc_addr", mem_addr, 16'h0020);
      check_val("wr_acc_wdata", mem_wdata, 16'h1234);
    end
    step();
    check_val("wr5_dm_ready", {15'd0, dm_ready}, 16'd1);
    check_val("wr5_if_ready", {15'd0, if_ready}, 16'd0);
    check_val("wr5_stall", {15'd0, stall_dm}, 16'd0);
    check_val("wr5_mem_we", {15'd0, mem_we}, 16'd0);
    dm_we = 1'b0; dm_wdata = 16'h0000;
    step();

    // DM read back of 0x0020
    dm_re = 1'b1; dm_addr = 16'h0020;
    for (int c = 1; c <= 4; c++) step();
    step();
    check_val("rd5_dm_ready", {15'd0, dm_ready}, 16'd1);
    check_val("rd5_dm_rdata", dm_rdata, 16'h1234);
    check_val("rd5_if_rdata", if_rdata, 16'hBEEF);
    dm_re = 1'b0;
    step();

    // simultaneous IF and DM requests: DM first, IF granted in cycle 6
    if_req = 1'b1; if_addr = 16'h0010;
    dm_re = 1'b1; dm_addr = 16'h0020;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val("sim_dm_addr", mem_addr, 16'h0020);
      check_val("sim_dm_re", {15'd0, mem_re}, 16'd1);
    end
    step();
    check_val("sim5_dm_ready", {15'd0, dm_ready}, 16'd1);
    check_val("sim5_if_ready", {15'd0, if_ready}, 16'd0);
    check_val("sim5_stall_if", {15'd0, stall_if}, 16'd1);
    dm_re = 1'b0;
    step();
    check_val("sim6_mem_re", {15'd0, mem_re}, 16'd0);
    check_val("sim6_ready", {14'd0, if_ready, dm_ready}, 16'd0);
    for (int c = 7; c <= 10; c++) begin
      step();
      check_val("sim_if_addr", mem_addr, 16'h0010);
      check_val("sim_if_re", {15'd0, mem_re}, 16'd1);
      check_val("sim_if_ready", {15'd0, if_ready}, 16'd0);
    end
    step();
    check_val("sim11_if_ready", {15'd0, if_ready}, 16'd1);
    check_val("sim11_dm_ready", {15'd0, dm_ready}, 16'd0);
    check_val("sim11_if_rdata", if_rdata, 16'hBEEF);
    if_req = 1'b0;
    step();

    // dm_re and dm_we together behave as a write
    dm_re = 1'b1; dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h5A5A;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val("rw_acc_we", {15'd0, mem_we}, 16'd1);
      check_val("rw_acc_re", {15'd0, mem_re}, 16'd0);
    end
    step();
    check_val("rw5_dm_ready", {15'd0, dm_ready}, 16'd1);
    check_val("rw5_dm_rdata", dm_rdata, 16'h1234);
    dm_re = 1'b0; dm_we = 1'b0; dm_wdata = 16'h0000;
    step();
    dm_re = 1'b1; dm_addr = 16'h0030;
    for (int c = 1; c <= 4; c++) step();
    step();
    check_val("rw_rd_ready", {15'd0, dm_ready}, 16'd1);
    check_val("rw_rd_rdata", dm_rdata, 16'h5A5A);
    dm_re = 1'b0;
    step();

    // reset pulsed in cycle 2 of an IF read of 0x0040
    if_req = 1'b1; if_addr = 16'h0040;
    step();
    step();
    check_val("rm2_mem_re", {15'd0, mem_re}, 16'd1);
    rst = 1'b1;
    step();
    check_val("rm3_mem_re", {15'd0, mem_re}, 16'd0);
    check_val("rm3_mem_addr", mem_addr, 16'h0000);
    check_val("rm3_if_ready", {15'd0, if_ready}, 16'd0);
    check_val("rm3_if_rdata", if_rdata, 16'h0000);
    rst = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      step();
      check_val("rm_acc_re", {15'd0, mem_re}, 16'd1);
      check_val("rm_acc_addr", mem_addr, 16'h0040);
      check_val("rm_acc_ready", {15'd0, if_ready}, 16'd0);
    end
    step();
    check_val("rm8_if_ready", {15'd0, if_ready}, 16'd1);
    check_val("rm8_if_rdata", if_rdata, 16'h0F0F);
    if_req = 1'b0;
    step();
    check_val("rm9_if_ready", {15'd0, if_ready}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
